// File: rtl/pe_group_acc.sv
// Grouped 3x3 multi-channel MAC with bias preload, saturating pass accumulation
// and a valid/ready output register. Three register stages: products, group sum, result.
module pe_group_acc #(
    parameter int CH     = 4,
    parameter int DATA_W = 9,
    parameter int KER_W  = 16,
    parameter int ACC_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [CH*9*DATA_W-1:0]    in_data,
    input  logic [CH*9*KER_W-1:0]     in_kernel,
    input  logic [ACC_W-1:0]          in_bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_sum,
    output logic                      out_ovf
);

    localparam int NT  = CH * 9;
    localparam int PW  = DATA_W + KER_W;
    localparam int SW  = PW + 4;
    localparam int GW  = SW + $clog2(CH);
    localparam int AW1 = ACC_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic en;

    logic                    s1_valid, s1_first, s1_last;
    logic [ACC_W-1:0]        s1_bias;
    logic signed [PW-1:0]    prod_q [NT];

    logic signed [SW-1:0]    ch_sum [CH];
    logic signed [GW-1:0]    group_d;

    logic                    s2_valid, s2_first, s2_last;
    logic [ACC_W-1:0]        s2_bias;
    logic signed [GW-1:0]    group_q;

    logic signed [ACC_W-1:0] acc_q;
    logic                    ovf_q;
    logic signed [ACC_W-1:0] base;
    logic signed [AW1-1:0]   sum_wide;
    logic signed [ACC_W-1:0] new_acc;
    logic                    sat_hit;
    logic                    ovf_new;

    // One shared enable: the whole pipe stalls only when a result is waiting unaccepted.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_bias  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_first <= in_first;
                s1_last  <= in_last;
                s1_bias  <= in_bias;
            end
        end
    end

    // Products load only on real beats so undefined idle data never enters the pipe.
    always_ff @(posedge clk) begin
        if (en && in_valid) begin
            for (int t = 0; t < NT; t++) begin
                prod_q[t] <= PW'($signed(in_data[t*DATA_W +: DATA_W])) *
                             PW'($signed(in_kernel[t*KER_W +: KER_W]));
            end
        end
    end

    always_comb begin
        group_d = '0;
        for (int c = 0; c < CH; c++) begin
            ch_sum[c] = '0;
            for (int t = 0; t < 9; t++) begin
                ch_sum[c] = ch_sum[c] + SW'(prod_q[c*9+t]);
            end
            group_d = group_d + GW'(ch_sum[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_bias  <= '0;
            group_q  <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_first <= s1_first;
                s2_last  <= s1_last;
                s2_bias  <= s1_bias;
                group_q  <= group_d;
            end
        end
    end

    // One spare bit catches overflow of base + group before clamping.
    always_comb begin
        base     = s2_first ? $signed(s2_bias) : acc_q;
        sum_wide = AW1'(base) + AW1'(group_q);
        sat_hit  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        new_acc  = sat_hit ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_W-1:0];
        ovf_new  = (s2_first ? 1'b0 : ovf_q) | sat_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (en && s2_valid) begin
                if (s2_last) begin
                    out_sum   <= new_acc;
                    out_ovf   <= ovf_new;
                    out_valid <= 1'b1;
                    acc_q     <= '0;
                    ovf_q     <= 1'b0;
                end else begin
                    acc_q <= new_acc;
                    ovf_q <= ovf_new;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_group_acc.sv
// Directed and randomised bench for pe_group_acc; expected results come from
// hand-computed constants and a behavioural saturating accumulator model.
module tb_pe_group_acc;

    localparam int CH     = 4;
    localparam int DATA_W = 9;
    localparam int KER_W  = 16;
    localparam int ACC_W  = 32;
    localparam int NT     = CH * 9;

    localparam longint MAXV = 2147483647;
    localparam longint MINV = -longint'(2147483647) - 1;

    localparam int RDY_ON    = 0;
    localparam int RDY_STALL = 1;
    localparam int RDY_RAND  = 2;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } exp_t;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_first;
    logic                   in_last;
    logic [NT*DATA_W-1:0]   in_data;
    logic [NT*KER_W-1:0]    in_kernel;
    logic [ACC_W-1:0]       in_bias;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_sum;
    logic                   out_ovf;

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int ready_mode = RDY_ON;
    int stall_left = 0;
    int stall_obs  = 0;

    logic [NT*DATA_W-1:0]   beat_data;
    logic [NT*KER_W-1:0]    beat_ker;
    longint                 m_acc = 0;
    bit                     m_ovf = 0;

    pe_group_acc #(
        .CH(CH), .DATA_W(DATA_W), .KER_W(KER_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_first(in_first),
        .in_last(in_last),
        .in_data(in_data),
        .in_kernel(in_kernel),
        .in_bias(in_bias),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream readiness: always on, a fixed stall after the first result, or random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                RDY_STALL: begin
                    if (out_valid && stall_left > 0) begin
                        out_ready  = 1'b0;
                        stall_left = stall_left - 1;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                RDY_RAND: out_ready = ($urandom_range(0, 3) != 0);
                default:  out_ready = 1'b1;
            endcase
        end
    end

    task automatic check_output(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every accepted result is popped against the scoreboard in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (!out_valid) check_output("in_ready_idle", ACC_W'(in_ready), ACC_W'(1));
            if (out_valid && !out_ready) begin
                check_output("in_ready_stall", ACC_W'(in_ready), ACC_W'(0));
                stall_obs++;
            end
            if (out_valid && out_ready) begin
                check_output("unexpected_output", ACC_W'(exp_q.size() != 0), ACC_W'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check_output("out_sum", out_sum, mon_e.sum);
                    check_output("out_ovf", ACC_W'(out_ovf), ACC_W'(mon_e.ovf));
                end
            end
        end
    end

    function automatic longint beat_dot(input logic [NT*DATA_W-1:0] d, input logic [NT*KER_W-1:0] k);
        longint s = 0;
        for (int t = 0; t < NT; t++) begin
            s += longint'($signed(d[t*DATA_W +: DATA_W])) * longint'($signed(k[t*KER_W +: KER_W]));
        end
        return s;
    endfunction

    task automatic set_uniform(input int d, input int k);
        for (int t = 0; t < NT; t++) begin
            beat_data[t*DATA_W +: DATA_W] = DATA_W'(d);
            beat_ker[t*KER_W +: KER_W]    = KER_W'(k);
        end
    endtask

    task automatic set_random();
        for (int t = 0; t < NT; t++) begin
            beat_data[t*DATA_W +: DATA_W] = DATA_W'($urandom());
            beat_ker[t*KER_W +: KER_W]    = KER_W'($urandom());
        end
    endtask

    task automatic apply_stimulus(input logic first, input logic last, input logic [ACC_W-1:0] bias);
        bit ok = 0;
        in_valid  = 1'b1;
        in_first  = first;
        in_last   = last;
        in_bias   = bias;
        in_data   = beat_data;
        in_kernel = beat_ker;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        check_output("accept_timeout", ACC_W'(ok), ACC_W'(1));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_data   = 'x;
        in_kernel = 'x;
    endtask

    task automatic send_pixel(input int passes, input longint bias, input bit rnd, input int dval,
                              input int kval, input bit use_model, input longint exp_sum,
                              input bit exp_ovf, input bit bubbles);
        longint nv;
        bit sat;
        for (int p = 0; p < passes; p++) begin
            if (rnd) set_random();
            else set_uniform(dval, kval);
            nv  = ((p == 0) ? bias : m_acc) + beat_dot(beat_data, beat_ker);
            sat = 0;
            if (nv > MAXV) begin
                nv  = MAXV;
                sat = 1;
            end else if (nv < MINV) begin
                nv  = MINV;
                sat = 1;
            end
            m_ovf = ((p == 0) ? 1'b0 : m_ovf) | sat;
            m_acc = nv;
            if (p == passes - 1) begin
                if (use_model) exp_q.push_back('{sum: nv[ACC_W-1:0], ovf: m_ovf});
                else exp_q.push_back('{sum: exp_sum[ACC_W-1:0], ovf: exp_ovf});
                m_acc = 0;
                m_ovf = 0;
            end
            apply_stimulus(p == 0, p == passes - 1, bias[ACC_W-1:0]);
            if (bubbles) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check_output("drain_timeout", ACC_W'(ok), ACC_W'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        int b;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_data   = 'x;
        in_kernel = 'x;
        in_bias   = '0;
        beat_data = '0;
        beat_ker  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check_output("rst_out_valid", ACC_W'(out_valid), ACC_W'(0));
        check_output("rst_out_sum", out_sum, ACC_W'(0));
        check_output("rst_out_ovf", ACC_W'(out_ovf), ACC_W'(0));
        check_output("rst_in_ready", ACC_W'(in_ready), ACC_W'(1));
        @(posedge clk);
        #1;

        // Single-pass pixel: 36 taps of 1*1, result exactly three cycles after accept.
        send_pixel(1, 0, 0, 1, 1, 0, 36, 0, 0);
        @(negedge clk);
        check_output("lat_cycle1", ACC_W'(out_valid), ACC_W'(0));
        @(negedge clk);
        check_output("lat_cycle2", ACC_W'(out_valid), ACC_W'(0));
        @(negedge clk);
        check_output("lat_cycle3", ACC_W'(out_valid), ACC_W'(1));
        wait_drain();

        // first=0 right after a last starts from zero and ignores the bias.
        set_uniform(1, 1);
        exp_q.push_back('{sum: 32'd36, ovf: 1'b0});
        apply_stimulus(1'b0, 1'b1, 32'd999);
        wait_drain();

        send_pixel(2, -10, 0, 2, -3, 0, -442, 0, 0);
        wait_drain();

        // Back-to-back pixels with a four-cycle downstream stall on the first result.
        stall_obs  = 0;
        stall_left = 4;
        ready_mode = RDY_STALL;
        for (int k = 1; k <= 5; k++) begin
            send_pixel(1, 0, 0, k, 1, 0, 36 * k, 0, 0);
        end
        wait_drain();
        check_output("stall_cycles", ACC_W'(stall_obs), ACC_W'(4));
        ready_mode = RDY_ON;

        send_pixel(8, 0, 0, -256, -32768, 0, MAXV, 1, 0);
        send_pixel(1, 0, 0, 0, 0, 0, 0, 0, 0);
        wait_drain();

        // Reset after two of three passes must swallow the partial pixel.
        set_uniform(1, 1);
        apply_stimulus(1'b1, 1'b0, 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_output("reset_no_output", ACC_W'(seen), ACC_W'(0));
        @(posedge clk);
        #1;
        send_pixel(1, 5, 0, 1, 1, 0, 41, 0, 0);
        wait_drain();

        ready_mode = RDY_RAND;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) b = int'($urandom());
            else b = int'($urandom_range(0, 2000)) - 1000;
            send_pixel(int'($urandom_range(1, 4)), longint'(b), 1, 0, 0, 1, 0, 0, 1);
        end
        wait_drain();
        ready_mode = RDY_ON;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
